// File: rtl/id_gen_if.sv
// Request/character-stream bundle between id_gen and whatever drives or consumes it.
// Latency: none, wires only.
// Backpressure: none; the stream is free-running once a request is accepted.
//   master (generator side): start, let_cnt, dig_cnt, let_off, dig_off in; char, valid, busy, done, match_exp out
//   slave  (requester/consumer side): the mirror image
interface id_gen_if;
    logic       start;
    logic [3:0] let_cnt;
    logic [3:0] dig_cnt;
    logic [4:0] let_off;
    logic [3:0] dig_off;
    logic [7:0] char;
    logic       valid;
    logic       busy;
    logic       done;
    logic       match_exp;

    modport master (
        input  start, let_cnt, dig_cnt, let_off, dig_off,
        output char, valid, busy, done, match_exp
    );

    modport slave (
        output start, let_cnt, dig_cnt, let_off, dig_off,
        input  char, valid, busy, done, match_exp
    );
endinterface

// File: rtl/id_gen.sv
// Identifier stream generator: N letters, M digits, then a separator, one char per clock.
// Latency: first character one cycle after start is accepted; all outputs registered.
// Backpressure: none; start is only honoured in IDLE or on the separator cycle, ignored otherwise.
//   clk, reset (async, active-high) are plain ports; bus (id_gen_if.master) carries the
//   request fields in and char/valid/busy/done/match_exp out.
module id_gen #(
    parameter logic [7:0] SEP_CHAR  = 8'h2F,
    parameter logic [7:0] IDLE_CHAR = 8'h00
) (
    input  logic     clk,
    input  logic     reset,
    id_gen_if.master bus
);

    typedef enum logic [1:0] {S_IDLE, S_LET, S_DIG, S_SEP} state_t;

    state_t     r_state,   w_nx_state;
    logic [3:0] r_let_cnt, w_nx_let_cnt;
    logic [3:0] r_dig_cnt, w_nx_dig_cnt;
    logic [4:0] r_let_off, w_nx_let_off;
    logic [3:0] r_dig_off, w_nx_dig_off;
    logic [3:0] r_let_i,   w_nx_let_i;
    logic [3:0] r_dig_i,   w_nx_dig_i;

    logic [7:0] r_char,  w_nx_char;
    logic       r_valid, w_nx_valid;
    logic       r_busy,  w_nx_busy;
    logic       r_done,  w_nx_done;
    logic       r_match, w_nx_match;

    // Next state, counters and latched request fields. State/index registers describe the
    // character currently on the outputs, so "next" values describe the next character.
    always_comb begin
        w_nx_state   = r_state;
        w_nx_let_cnt = r_let_cnt;
        w_nx_dig_cnt = r_dig_cnt;
        w_nx_let_off = r_let_off;
        w_nx_dig_off = r_dig_off;
        w_nx_let_i   = r_let_i;
        w_nx_dig_i   = r_dig_i;
        case (r_state)
            S_IDLE, S_SEP: begin
                w_nx_state = S_IDLE;
                if (bus.start) begin
                    w_nx_let_cnt = bus.let_cnt;
                    w_nx_dig_cnt = bus.dig_cnt;
                    // Out-of-range offsets fold to the first symbol of the alphabet.
                    w_nx_let_off = (bus.let_off >= 5'd26) ? 5'd0 : bus.let_off;
                    w_nx_dig_off = (bus.dig_off >= 4'd10) ? 4'd0 : bus.dig_off;
                    w_nx_let_i   = 4'd0;
                    w_nx_dig_i   = 4'd0;
                    if (bus.let_cnt != 4'd0)
                        w_nx_state = S_LET;
                    else if (bus.dig_cnt != 4'd0)
                        w_nx_state = S_DIG;
                    else
                        w_nx_state = S_SEP;
                end
            end
            S_LET: begin
                if (r_let_i == r_let_cnt - 4'd1) begin
                    if (r_dig_cnt != 4'd0)
                        w_nx_state = S_DIG;
                    else
                        w_nx_state = S_SEP;
                end else begin
                    w_nx_let_i = r_let_i + 4'd1;
                end
            end
            S_DIG: begin
                if (r_dig_i == r_dig_cnt - 4'd1)
                    w_nx_state = S_SEP;
                else
                    w_nx_dig_i = r_dig_i + 4'd1;
            end
            default: w_nx_state = S_IDLE;
        endcase
    end

    // Alphabet position of the next character. Letter sum peaks at 25+15=40, so one
    // subtract of 26 suffices; digit sum peaks at 9+15=24, which needs two subtracts of 10.
    logic [5:0] w_let_sum, w_let_idx;
    logic [4:0] w_dig_sum, w_dig_r1, w_dig_idx;

    assign w_let_sum = {1'b0, w_nx_let_off} + {2'b00, w_nx_let_i};
    assign w_let_idx = (w_let_sum >= 6'd26) ? (w_let_sum - 6'd26) : w_let_sum;
    assign w_dig_sum = {1'b0, w_nx_dig_off} + {1'b0, w_nx_dig_i};
    assign w_dig_r1  = (w_dig_sum >= 5'd10) ? (w_dig_sum - 5'd10) : w_dig_sum;
    assign w_dig_idx = (w_dig_r1  >= 5'd10) ? (w_dig_r1  - 5'd10) : w_dig_r1;

    always_comb begin
        w_nx_char  = IDLE_CHAR;
        w_nx_valid = 1'b0;
        w_nx_busy  = 1'b0;
        w_nx_done  = 1'b0;
        w_nx_match = 1'b0;
        case (w_nx_state)
            S_LET: begin
                w_nx_char  = 8'h61 + {2'b00, w_let_idx};
                w_nx_valid = 1'b1;
                w_nx_busy  = 1'b1;
            end
            S_DIG: begin
                w_nx_char  = 8'h30 + {3'b000, w_dig_idx};
                w_nx_valid = 1'b1;
                w_nx_busy  = 1'b1;
                // A recognizer only fires on digits that follow at least one letter.
                w_nx_match = (w_nx_let_cnt != 4'd0);
            end
            S_SEP: begin
                w_nx_char  = SEP_CHAR;
                w_nx_valid = 1'b1;
                w_nx_busy  = 1'b1;
                w_nx_done  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_let_cnt <= 4'd0;
            r_dig_cnt <= 4'd0;
            r_let_off <= 5'd0;
            r_dig_off <= 4'd0;
            r_let_i   <= 4'd0;
            r_dig_i   <= 4'd0;
            r_char    <= IDLE_CHAR;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_match   <= 1'b0;
        end else begin
            r_state   <= w_nx_state;
            r_let_cnt <= w_nx_let_cnt;
            r_dig_cnt <= w_nx_dig_cnt;
            r_let_off <= w_nx_let_off;
            r_dig_off <= w_nx_dig_off;
            r_let_i   <= w_nx_let_i;
            r_dig_i   <= w_nx_dig_i;
            r_char    <= w_nx_char;
            r_valid   <= w_nx_valid;
            r_busy    <= w_nx_busy;
            r_done    <= w_nx_done;
            r_match   <= w_nx_match;
        end
    end

    assign bus.char      = r_char;
    assign bus.valid     = r_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.match_exp = r_match;

endmodule

// File: tb/tb_id_gen.sv
// Directed bench for id_gen: table of request vectors with hand-written expected streams,
// plus sequences for back-to-back requests, ignored start pulses and async mid-string reset.
// Inputs driven and outputs sampled on the falling edge.
module tb_id_gen;

    logic clk = 1'b0;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;

    localparam logic [11:0] IDLE_EXP = 12'h000;

    id_gen_if bus();

    id_gen #(
        .SEP_CHAR  (8'h2F),
        .IDLE_CHAR (8'h00)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] lc;
        logic [3:0] dc;
        logic [4:0] lo;
        logic [3:0] dof;
        string      chars;
        string      mask;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [11:0] exp);
        logic [11:0] act;
        act = {bus.char, bus.valid, bus.busy, bus.done, bus.match_exp};
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got char=%h valid=%b busy=%b done=%b match=%b, want char=%h valid=%b busy=%b done=%b match=%b",
                     name, act[11:4], act[3], act[2], act[1], act[0],
                     exp[11:4], exp[3], exp[2], exp[1], exp[0]);
    endtask

    task automatic set_req(input logic [3:0] lc, input logic [3:0] dc,
                           input logic [4:0] lo, input logic [3:0] dof);
        bus.let_cnt = lc;
        bus.dig_cnt = dc;
        bus.let_off = lo;
        bus.dig_off = dof;
    endtask

    // Expected output word for stream character k of chars/mask.
    function automatic logic [11:0] stream_exp(input string chars, input string mask, input int k);
        logic [7:0] c;
        logic       m;
        c = chars[k];
        m = (mask[k] == 8'h31);
        return {c, 1'b1, 1'b1, (c == 8'h2F), m};
    endfunction

    task automatic run_vec(input vec_t v);
        set_req(v.lc, v.dc, v.lo, v.dof);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < v.chars.len(); k++) begin
            check($sformatf("%s[%0d]", v.name, k), stream_exp(v.chars, v.mask, k));
            @(negedge clk);
        end
        check({v.name, "_idle"}, IDLE_EXP);
    endtask

    initial begin
        vecs[0] = '{"basic",    4'd4,  4'd4,  5'd0,  4'd1, "abcd1234/",                       "000011110"};
        vecs[1] = '{"wrap",     4'd3,  4'd12, 5'd24, 4'd8, "yza890123456789/",                "0001111111111110"};
        vecs[2] = '{"letclamp", 4'd2,  4'd1,  5'd30, 4'd0, "ab0/",                            "0010"};
        vecs[3] = '{"digonly",  4'd0,  4'd2,  5'd0,  4'd0, "01/",                             "000"};
        vecs[4] = '{"seponly",  4'd0,  4'd0,  5'd3,  4'd3, "/",                               "0"};
        vecs[5] = '{"maxlen",   4'd15, 4'd15, 5'd20, 4'd15, "uvwxyzabcdefghi012345678901234/", "0000000000000001111111111111110"};
        vecs[6] = '{"digwrap2", 4'd1,  4'd15, 5'd25, 4'd9, "z901234567890123/",               "01111111111111110"};

        reset     = 1'b1;
        bus.start = 1'b0;
        set_req(4'd0, 4'd0, 5'd0, 4'd0);
        @(negedge clk);
        @(negedge clk);
        check("reset_state", IDLE_EXP);
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_reset", IDLE_EXP);

        for (int i = 0; i < 7; i++)
            run_vec(vecs[i]);

        // start held high: back-to-back strings with no idle gap
        begin
            string exp_s;
            string mask_s;
            exp_s  = "a0/a0/a0/";
            mask_s = "010010010";
            set_req(4'd1, 4'd1, 5'd0, 4'd0);
            bus.start = 1'b1;
            @(negedge clk);
            for (int k = 0; k < 9; k++) begin
                check($sformatf("b2b[%0d]", k), stream_exp(exp_s, mask_s, k));
                if (k == 8) bus.start = 1'b0;
                @(negedge clk);
            end
            check("b2b_idle", IDLE_EXP);
        end

        // start pulses during LET and DIG with different fields must be ignored
        begin
            string exp_s;
            string mask_s;
            exp_s  = "abc012/";
            mask_s = "0001110";
            set_req(4'd3, 4'd3, 5'd0, 4'd0);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            set_req(4'd0, 4'd0, 5'd5, 4'd5);
            for (int k = 0; k < 7; k++) begin
                check($sformatf("ignore[%0d]", k), stream_exp(exp_s, mask_s, k));
                bus.start = (k == 1 || k == 4);
                @(negedge clk);
            end
            check("ignore_idle", IDLE_EXP);
        end

        // asynchronous reset in the middle of DIG, between clock edges
        begin
            string exp_s;
            string mask_s;
            exp_s  = "ab01234/";
            mask_s = "00111110";
            set_req(4'd2, 4'd5, 5'd0, 4'd0);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            for (int k = 0; k < 4; k++) begin
                check($sformatf("prerst[%0d]", k), stream_exp(exp_s, mask_s, k));
                if (k < 3) @(negedge clk);
            end
            #2;
            reset = 1'b1;
            #1;
            check("async_reset_mid_dig", IDLE_EXP);
            @(negedge clk);
            check("reset_held", IDLE_EXP);
            reset = 1'b0;
            @(negedge clk);
            check("idle_after_rst2", IDLE_EXP);
            run_vec(vecs[0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
